// File: rtl/proctypes.sv
// proctypes: shared instruction bank types and loader state encoding
package proctypes;
  typedef logic [31:0] InstructionAddr;
  typedef logic [15:0] Instruction;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, INST_LO, INST_HI, WRITE, CHECK} LoaderState;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: counts idle cycles while armed, flags expiry on the cycle the limit is reached
module loader_timeout #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] elapsed;
  always_ff @(posedge clk or posedge rst)
    if (rst) elapsed <= '0;
    else elapsed <= (kick || !enable) ? '0 : elapsed + 1'b1;
  assign expired = enable && !kick && elapsed == W'(CYCLES - 1);
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: framed byte stream to instruction_bank writer with XOR checksum and timeout
module instruction_loader
  import proctypes::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int unsigned BANK_DEPTH     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        bank_we,
  output logic [31:0] bank_addr,
  output logic [15:0] bank_data,
  input  logic        bank_ready,
  output logic        loading,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_written
);
  localparam logic [15:0] DEPTH = 16'(BANK_DEPTH);
  LoaderState  state;
  logic [15:0] count;
  logic [7:0]  lo, csum;
  logic        xfer, expired;
  logic [15:0] n, next_words;
  assign xfer       = byte_valid && byte_ready;
  assign n          = {byte_data, count[7:0]};
  assign next_words = words_written + 16'd1;

  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .kick(xfer),
    .enable(loading && state != WRITE), .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      byte_ready <= 1'b1;
      bank_we <= 1'b0;
      bank_addr <= '0;
      bank_data <= '0;
      loading <= 1'b0;
      load_done <= 1'b0;
      load_error <= 1'b0;
      words_written <= '0;
      count <= '0;
      lo <= '0;
      csum <= '0;
    end else if (expired) begin
      state <= IDLE;
      load_error <= 1'b1;
      loading <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer && byte_data == SYNC_BYTE) begin
          state <= LEN_LO;
          load_done <= 1'b0;
          load_error <= 1'b0;
          words_written <= '0;
          csum <= '0;
          loading <= 1'b1;
        end
        LEN_LO: if (xfer) begin
          count[7:0] <= byte_data;
          state <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          count <= n;
          if (n > DEPTH) begin
            state <= IDLE;
            load_error <= 1'b1;
            loading <= 1'b0;
          end else state <= (n == '0) ? CHECK : INST_LO;
        end
        INST_LO: if (xfer) begin
          lo <= byte_data;
          csum <= csum ^ byte_data;
          state <= INST_HI;
        end
        INST_HI: if (xfer) begin
          csum <= csum ^ byte_data;
          bank_data <= {byte_data, lo};
          bank_addr <= {16'd0, words_written};
          bank_we <= 1'b1;
          byte_ready <= 1'b0;
          state <= WRITE;
        end
        WRITE: if (bank_ready) begin
          words_written <= next_words;
          bank_we <= 1'b0;
          byte_ready <= 1'b1;
          state <= (next_words == count) ? CHECK : INST_LO;
        end
        CHECK: if (xfer) begin
          load_done <= byte_data == csum;
          load_error <= byte_data != csum;
          loading <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed frames against instruction_loader with a write monitor
module tb_instruction_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, bank_we, bank_ready = 1'b1;
  logic [31:0] bank_addr;
  logic [15:0] bank_data, words_written;
  logic        loading, load_done, load_error;
  int          tests = 0, fails = 0;
  logic [31:0] wa[$];
  logic [15:0] wd[$];

  instruction_loader #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_data(bank_data), .bank_ready(bank_ready), .loading(loading),
    .load_done(load_done), .load_error(load_error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bank_we && bank_ready) begin
      wa.push_back(bank_addr);
      wd.push_back(bank_data);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_wait", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum_byte);
    logic [7:0] f[7] = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    foreach (f[i]) send(f[i]);
    chk("loading_before_csum", 32'(loading), 32'd1);
    send(csum_byte);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'd1);
    chk("rst_outputs", {bank_we, loading, load_done, load_error}, 32'd0);
    chk("rst_addr", bank_addr, 32'd0);
    chk("rst_data", 32'(bank_data), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(8'h00);
    send(8'hFF);
    chk("garbage_loading", 32'(loading), 32'd0);
    send_frame(8'h08);
    chk("good_done", 32'(load_done), 32'd1);
    chk("good_error", 32'(load_error), 32'd0);
    chk("good_loading", 32'(loading), 32'd0);
    chk("good_words", 32'(words_written), 32'd2);
    chk("good_nwrites", wa.size(), 32'd2);
    chk("good_w0", {wa[0][15:0], wd[0]}, 32'h0000_1234);
    chk("good_w1", {wa[1][15:0], wd[1]}, 32'h0001_5678);
    send_frame(8'h00);
    chk("bad_csum_error", 32'(load_error), 32'd1);
    chk("bad_csum_done", 32'(load_done), 32'd0);
    chk("bad_csum_nwrites", wa.size(), 32'd4);
    chk("bad_csum_w1", {wa[3][15:0], wd[3]}, 32'h0001_5678);
    send(8'hA5);
    send(8'h01);
    send(8'h04);
    chk("oversize_error", 32'(load_error), 32'd1);
    chk("oversize_loading", 32'(loading), 32'd0);
    chk("oversize_nwrites", wa.size(), 32'd4);
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("empty_done", 32'(load_done), 32'd1);
    chk("empty_error", 32'(load_error), 32'd0);
    chk("empty_words", 32'(words_written), 32'd0);
    bank_ready = 1'b0;
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'hCD);
    send(8'hAB);
    for (int i = 0; i < 5; i++) begin
      chk("stall_we", 32'(bank_we), 32'd1);
      chk("stall_ready", 32'(byte_ready), 32'd0);
      chk("stall_addr_data", {bank_addr[15:0], bank_data}, 32'h0000_ABCD);
      @(negedge clk);
    end
    chk("stall_nwrites", wa.size(), 32'd4);
    bank_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_we", 32'(bank_we), 32'd0);
    chk("stall_done_words", 32'(words_written), 32'd1);
    chk("stall_nwrites_after", wa.size(), 32'd5);
    chk("stall_w", {wa[4][15:0], wd[4]}, 32'h0000_ABCD);
    send(8'h66);
    chk("stall_frame_done", 32'(load_done), 32'd1);
    send(8'hA5);
    send(8'h01);
    for (int i = 1; i < 20; i++) @(negedge clk);
    chk("timeout_early", 32'(load_error), 32'd0);
    chk("timeout_early_loading", 32'(loading), 32'd1);
    @(negedge clk);
    chk("timeout_error", 32'(load_error), 32'd1);
    chk("timeout_loading", 32'(loading), 32'd0);
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h11);
    #2 rst = 1'b1;
    #1;
    chk("arst_loading", 32'(loading), 32'd0);
    chk("arst_ready", 32'(byte_ready), 32'd1);
    chk("arst_flags", {bank_we, load_done, load_error}, 32'd0);
    chk("arst_words", 32'(words_written), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h22);
    repeat (2) @(negedge clk);
    chk("arst_no_write", wa.size(), 32'd5);
    chk("arst_idle", 32'(loading), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
